// File: rtl/combo_lock_seq.sv
// ============================================================================
// combo_lock_seq : multi-digit combination lock with fail counting, timed
//                  lockout and re-programmable password. Optional feature
//                  macro: AUTO_RELOCK_EN (idle auto-relock from OPENED).
// Revision: 1.0
// ============================================================================
`default_nettype none

module combo_lock_seq #(
    parameter int DIGIT_W        = 4,
    parameter int DIGITS         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024,
    parameter int RELOCK_CYCLES  = 4096,
    parameter int CNT_W          = 16,
    parameter int BLINK_BIT      = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DIGIT_W-1:0]               digit_in,
    input  logic                             digit_valid,
    input  logic                             enter,
    input  logic                             cancel,
    input  logic                             set_req,
    output logic                             opened,
    output logic                             alarm,
    output logic                             locked_out,
    output logic [2:0]                       state_o,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fails_o
);

    localparam int BUF_W   = DIGITS * DIGIT_W;
    localparam int IDX_W   = $clog2(DIGITS + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
    localparam logic [TMR_W-1:0]  RELOCK_LOAD = TMR_W'(RELOCK_CYCLES - 1);
`endif
    localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ENTRY     = 3'd1,
        OPENED    = 3'd2,
        SET_ENTRY = 3'd3,
        ALARM     = 3'd4,
        LOCKOUT   = 3'd5
    } state_t;

    state_t              state;
    logic [BUF_W-1:0]    entry_buf;
    logic [BUF_W-1:0]    password;
    logic [IDX_W-1:0]    idx;
    logic                ovf;
    logic [FAIL_W-1:0]   fails;
    logic [TMR_W-1:0]    timer;
    logic [CNT_W-1:0]    blink_cnt;

    logic                buf_full;
    logic                submit_ok;
    logic [FAIL_W-1:0]   fails_inc;
    logic [BUF_W-1:0]    capture_buf;

    always_comb begin
        buf_full    = (idx == IDX_FULL);
        submit_ok   = buf_full && !ovf;
        fails_inc   = (fails == FAIL_MAX) ? fails : fails + 1'b1;
        capture_buf = entry_buf;
        if (!buf_full) begin
            capture_buf[int'(idx)*DIGIT_W +: DIGIT_W] = digit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            password  <= '0;
            entry_buf <= '0;
            idx       <= '0;
            ovf       <= 1'b0;
            fails     <= '0;
            timer     <= '0;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (!cancel && !enter && digit_valid) begin
                        entry_buf <= BUF_W'(digit_in);
                        idx       <= IDX_W'(1);
                        ovf       <= 1'b0;
                        state     <= ENTRY;
                    end
                end

                ENTRY: begin
                    if (cancel) begin
                        state     <= IDLE;
                        entry_buf <= '0;
                        idx       <= '0;
                        ovf       <= 1'b0;
                    end else if (enter) begin
                        entry_buf <= '0;
                        idx       <= '0;
                        ovf       <= 1'b0;
                        if (submit_ok && (entry_buf == password)) begin
                            state <= OPENED;
                            fails <= '0;
`ifdef AUTO_RELOCK_EN
                            timer <= RELOCK_LOAD;
`endif
                        end else begin
                            fails <= fails_inc;
                            if (fails_inc == FAIL_MAX) begin
                                state <= LOCKOUT;
                                timer <= LOCK_LOAD;
                            end else begin
                                state <= ALARM;
                            end
                        end
                    end else if (digit_valid) begin
                        if (buf_full) begin
                            ovf <= 1'b1;
                        end else begin
                            entry_buf <= capture_buf;
                            idx       <= idx + 1'b1;
                        end
                    end
                end

                ALARM: begin
                    if (cancel) begin
                        state <= IDLE;
                    end
                end

                LOCKOUT: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        fails <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                OPENED: begin
                    if (cancel || enter) begin
                        state <= IDLE;
                    end else if (digit_valid) begin
`ifdef AUTO_RELOCK_EN
                        timer <= RELOCK_LOAD;
`endif
                    end else if (set_req) begin
                        state     <= SET_ENTRY;
                        entry_buf <= '0;
                        idx       <= '0;
                        ovf       <= 1'b0;
`ifdef AUTO_RELOCK_EN
                        timer     <= RELOCK_LOAD;
                    end else if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
`endif
                    end
                end

                SET_ENTRY: begin
                    if (cancel || enter) begin
                        entry_buf <= '0;
                        idx       <= '0;
                        ovf       <= 1'b0;
                        // A short or overflowed new password falls back to OPENED
                        if (!cancel && submit_ok) begin
                            password <= entry_buf;
                            state    <= IDLE;
                        end else begin
                            state <= OPENED;
`ifdef AUTO_RELOCK_EN
                            timer <= RELOCK_LOAD;
`endif
                        end
                    end else if (digit_valid) begin
                        if (buf_full) begin
                            ovf <= 1'b1;
                        end else begin
                            entry_buf <= capture_buf;
                            idx       <= idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign opened     = (state == OPENED);
    assign locked_out = (state == LOCKOUT);
    assign alarm      = (state == ALARM) ? blink_cnt[BLINK_BIT] : (state == LOCKOUT);
    assign state_o    = state;
    assign fails_o    = fails;

endmodule

`default_nettype wire

// File: tb/tb_combo_lock_seq.sv
// Scoreboard bench for combo_lock_seq: a per-cycle reference model pushes the
// expected outputs, a negedge monitor pops and compares them.
`default_nettype none

module tb_combo_lock_seq;

    localparam int DIGIT_W        = 4;
    localparam int DIGITS         = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int RELOCK_CYCLES  = 8;
    localparam int CNT_W          = 16;
    localparam int BLINK_BIT      = 8;
    localparam int FW             = $clog2(MAX_FAILS + 1);
`ifdef AUTO_RELOCK_EN
    localparam bit RELOCK_ON = 1'b1;
`else
    localparam bit RELOCK_ON = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPENED = 2, M_SET = 3, M_ALARM = 4, M_LOCK = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DIGIT_W-1:0] digit_in = '0;
    logic               digit_valid = 1'b0;
    logic               enter = 1'b0;
    logic               cancel = 1'b0;
    logic               set_req = 1'b0;
    logic               opened, alarm, locked_out;
    logic [2:0]         state_o;
    logic [FW-1:0]      fails_o;

    combo_lock_seq #(
        .DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RELOCK_CYCLES(RELOCK_CYCLES),
        .CNT_W(CNT_W), .BLINK_BIT(BLINK_BIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
        .enter(enter), .cancel(cancel), .set_req(set_req),
        .opened(opened), .alarm(alarm), .locked_out(locked_out),
        .state_o(state_o), .fails_o(fails_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        bit op;
        bit al;
        bit lo;
        int fl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_cyc = 0;

    // Reference model: the entry is kept as the list of every digit typed, so
    // a submission is acceptable exactly when that list has DIGITS elements.
    int          m_mode = M_IDLE;
    int          m_fails = 0;
    int          m_lock_left = 0;
    int          m_idle_left = 0;
    int          m_entry[$];
    int          m_pw[DIGITS];
    int unsigned m_cyc = 0;

    function automatic bit entry_is(input int pw[DIGITS]);
        if (m_entry.size() != DIGITS) return 1'b0;
        for (int i = 0; i < DIGITS; i++) if (m_entry[i] != pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit rn, input bit dv, input int d,
                              input bit en, input bit ca, input bit sr);
        if (!rn) begin
            m_mode = M_IDLE; m_fails = 0; m_lock_left = 0; m_idle_left = 0;
            m_entry.delete(); m_cyc = 0;
            for (int i = 0; i < DIGITS; i++) m_pw[i] = 0;
            return;
        end
        m_cyc = (m_cyc + 1) % (1 << CNT_W);
        case (m_mode)
            M_IDLE: if (!ca && !en && dv) begin
                m_entry.delete(); m_entry.push_back(d); m_mode = M_ENTRY;
            end
            M_ENTRY: begin
                if (ca) begin
                    m_entry.delete(); m_mode = M_IDLE;
                end else if (en) begin
                    if (entry_is(m_pw)) begin
                        m_mode = M_OPENED; m_fails = 0; m_idle_left = RELOCK_CYCLES;
                    end else begin
                        if (m_fails < MAX_FAILS) m_fails++;
                        if (m_fails == MAX_FAILS) begin
                            m_mode = M_LOCK; m_lock_left = LOCKOUT_CYCLES;
                        end else m_mode = M_ALARM;
                    end
                    m_entry.delete();
                end else if (dv && m_entry.size() <= DIGITS) m_entry.push_back(d);
            end
            M_ALARM: if (ca) m_mode = M_IDLE;
            M_LOCK: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_mode = M_IDLE; m_fails = 0; end
            end
            M_OPENED: begin
                if (ca || en) m_mode = M_IDLE;
                else if (dv) m_idle_left = RELOCK_CYCLES;
                else if (sr) begin m_entry.delete(); m_mode = M_SET; end
                else if (RELOCK_ON) begin
                    m_idle_left--;
                    if (m_idle_left == 0) m_mode = M_IDLE;
                end
            end
            M_SET: begin
                if (ca) begin
                    m_mode = M_OPENED; m_idle_left = RELOCK_CYCLES; m_entry.delete();
                end else if (en) begin
                    if (m_entry.size() == DIGITS) begin
                        for (int i = 0; i < DIGITS; i++) m_pw[i] = m_entry[i];
                        m_mode = M_IDLE;
                    end else begin
                        m_mode = M_OPENED; m_idle_left = RELOCK_CYCLES;
                    end
                    m_entry.delete();
                end else if (dv && m_entry.size() <= DIGITS) m_entry.push_back(d);
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic drive(input bit rn, input bit dv, input int d,
                         input bit en, input bit ca, input bit sr);
        exp_t e;
        @(negedge clk);
        rst_n = rn; digit_valid = dv; digit_in = d[DIGIT_W-1:0];
        enter = en; cancel = ca; set_req = sr;
        @(posedge clk);
        model_step(rn, dv, d, en, ca, sr);
        e.st = m_mode;
        e.op = (m_mode == M_OPENED);
        e.lo = (m_mode == M_LOCK);
        e.al = (m_mode == M_ALARM) ? bit'((m_cyc >> BLINK_BIT) & 1) : (m_mode == M_LOCK);
        e.fl = m_fails;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1, 0, 0, 0, 0, 0);
    endtask
    task automatic dig(input int d);  drive(1, 1, d, 0, 0, 0); endtask
    task automatic ent();             drive(1, 0, 0, 1, 0, 0); endtask
    task automatic can();             drive(1, 0, 0, 0, 1, 0); endtask
    task automatic setr();            drive(1, 0, 0, 0, 0, 1); endtask

    // Types n digits taken from the hex nibbles of v, most significant first.
    task automatic code(input int n, input int v);
        for (int i = n - 1; i >= 0; i--) dig((v >> (4 * i)) & 15);
    endtask

    always @(negedge clk) begin
        exp_t e;
        n_cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (state_o !== 3'(e.st) || opened !== e.op || alarm !== e.al ||
                locked_out !== e.lo || fails_o !== FW'(e.fl)) begin
                n_bad++;
                $display("FAIL outputs@cycle%0d: got st=%0d op=%b al=%b lo=%b fails=%0d, want st=%0d op=%b al=%b lo=%b fails=%0d",
                         n_cyc, state_o, opened, alarm, locked_out, fails_o,
                         e.st, e.op, e.al, e.lo, e.fl);
            end
        end
    end

    initial begin
        int r, len, pw_copy[DIGITS];
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        idle(2);

        code(4, 'h0000); ent(); idle(2);
        setr(); code(4, 'h1234); ent(); idle(1);
        code(4, 'h0000); ent(); can();
        code(4, 'h1234); ent(); can();

        for (int k = 0; k < 3; k++) begin
            code(4, 'h1235); ent(); can();
        end
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 0) can(); else dig(k & 15);
        end
        idle(2);

        code(5, 'h12344); ent(); can();
        code(3, 'h123); ent(); can();
        dig(1); drive(1, 0, 0, 1, 1, 0);
        code(4, 'h1234); ent();
        setr(); code(3, 'h987); ent(); can();
        code(4, 'h1234); ent();
        idle(12); can();

        for (int k = 0; k < 3; k++) begin
            code(4, 'h4321); ent(); can();
        end
        idle(5);
        drive(0, 0, 0, 0, 0, 0);
        idle(2);
        code(4, 'h0000); ent(); idle(3); can();

        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                pw_copy = m_pw;
                for (int i = 0; i < DIGITS; i++) dig(pw_copy[i]);
                ent();
            end else if (r < 35) begin
                len = $urandom_range(1, DIGITS + 1);
                repeat (len) dig($urandom_range(0, 3));
                ent();
            end else if (r < 48) can();
            else if (r < 58) setr();
            else if (r < 60) drive(0, 0, 0, 0, 0, 0);
            else if (r < 75) idle($urandom_range(1, 20));
            else begin
                case ($urandom_range(0, 3))
                    0: dig($urandom_range(0, 15));
                    1: ent();
                    2: can();
                    default: setr();
                endcase
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
